// File: rtl/inc_register_pkg.sv
// Shared op encoding and priority decode for the increment register bank.
// The testbench model reuses decode_op so both sides agree on op priority.
package inc_register_pkg;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_LOAD,
        OP_BCAST,
        OP_INC,
        OP_DEC
    } inc_op_t;

    // Reset is handled by the cell flops directly, so it decodes to HOLD here.
    function automatic inc_op_t decode_op(input logic rst, input logic wr, input logic bcast,
                                          input logic inc, input logic dec);
        inc_op_t op;
        op = OP_HOLD;
        if (rst)             op = OP_HOLD;
        else if (wr)         op = OP_LOAD;
        else if (bcast)      op = OP_BCAST;
        else if (inc && !dec) op = OP_INC;
        else if (dec && !inc) op = OP_DEC;
        return op;
    endfunction

endpackage

// File: rtl/inc_register_cell.sv
// One channel: value register plus a registered overflow pulse.
// Carry/borrow come from a WIDTH+1 bit add/subtract of the step.
module inc_register_cell
    import inc_register_pkg::*;
#(
    parameter int WIDTH    = 12,
    parameter int STEP     = 1,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  inc_op_t          op,
    input  logic [WIDTH-1:0] loadData,
    input  logic [WIDTH-1:0] bcastData,
    output logic [WIDTH-1:0] value,
    output logic             ovf
);

    localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP);

    logic [WIDTH:0] incSum;
    logic [WIDTH:0] decDiff;

    assign incSum  = {1'b0, value} + STEP_EXT;
    assign decDiff = {1'b0, value} - STEP_EXT;

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
            ovf   <= 1'b0;
        end else begin
            ovf <= 1'b0;
            case (op)
                OP_LOAD:  value <= loadData;
                OP_BCAST: value <= bcastData;
                OP_INC: begin
                    // Top bit of the extended sum is the carry out.
                    value <= (SATURATE != 0 && incSum[WIDTH]) ? '1 : incSum[WIDTH-1:0];
                    ovf   <= incSum[WIDTH];
                end
                OP_DEC: begin
                    value <= (SATURATE != 0 && decDiff[WIDTH]) ? '0 : decDiff[WIDTH-1:0];
                    ovf   <= decDiff[WIDTH];
                end
                default: value <= value;
            endcase
        end
    end

endmodule

// File: rtl/inc_register_bank.sv
// Bank of CORES independent increment registers with a shared broadcast load.
// Each channel decodes its own op; only bcastEn/bcastData are shared.
module inc_register_bank
    import inc_register_pkg::*;
#(
    parameter int WIDTH    = 12,
    parameter int CORES    = 4,
    parameter int STEP     = 1,
    parameter int SATURATE = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [CORES*WIDTH-1:0] dataIn,
    input  logic [CORES-1:0]       wrEn,
    input  logic [CORES-1:0]       incEn,
    input  logic [CORES-1:0]       decEn,
    input  logic [WIDTH-1:0]       bcastData,
    input  logic                   bcastEn,
    output logic [CORES*WIDTH-1:0] dataOut,
    output logic [CORES-1:0]       ovf
);

    for (genvar c = 0; c < CORES; c++) begin : gen_cell
        inc_op_t op;

        assign op = decode_op(rst, wrEn[c], bcastEn, incEn[c], decEn[c]);

        inc_register_cell #(
            .WIDTH   (WIDTH),
            .STEP    (STEP),
            .SATURATE(SATURATE)
        ) u_cell (
            .clk      (clk),
            .rst      (rst),
            .op       (op),
            .loadData (dataIn[c*WIDTH +: WIDTH]),
            .bcastData(bcastData),
            .value    (dataOut[c*WIDTH +: WIDTH]),
            .ovf      (ovf[c])
        );
    end

endmodule

// File: tb/tb_inc_register_bank.sv
// Bench for inc_register_bank: a wrap/step-1 instance and a saturate/step-3 instance
// share one stimulus stream and are checked every cycle against an integer model.
module tb_inc_register_bank;
    import inc_register_pkg::*;

    localparam int W    = 12;
    localparam int N    = 4;
    localparam int MAXV = (1 << W) - 1;
    localparam int EW   = N * W + N;

    // Clock / reset block
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst = 1'b1;
    logic [N*W-1:0] dataIn = '0;
    logic [N-1:0]   wrEn = '0, incEn = '0, decEn = '0;
    logic [W-1:0]   bcastData = '0;
    logic           bcastEn = 1'b0;

    logic [N*W-1:0] outW, outS;
    logic [N-1:0]   ovfW, ovfS;

    inc_register_bank #(.WIDTH(W), .CORES(N), .STEP(1), .SATURATE(0)) dutW (
        .clk(clk), .rst(rst), .dataIn(dataIn), .wrEn(wrEn), .incEn(incEn), .decEn(decEn),
        .bcastData(bcastData), .bcastEn(bcastEn), .dataOut(outW), .ovf(ovfW)
    );

    inc_register_bank #(.WIDTH(W), .CORES(N), .STEP(3), .SATURATE(1)) dutS (
        .clk(clk), .rst(rst), .dataIn(dataIn), .wrEn(wrEn), .incEn(incEn), .decEn(decEn),
        .bcastData(bcastData), .bcastEn(bcastEn), .dataOut(outS), .ovf(ovfS)
    );

    int compared = 0;
    int mismatched = 0;

    // Behavioural model: plain integer arithmetic, wrap by +/- 2^W, clamp to [0, MAXV].
    int mW[N], mS[N];
    bit oW[N], oS[N];
    bit modelValid = 1'b0;

    logic [EW-1:0] expW_q[$];
    logic [EW-1:0] expS_q[$];

    function automatic void model_next(input inc_op_t op, input int ld, input int bd,
                                       input int step, input bit sat,
                                       input int v, output int nv, output bit no);
        int n;
        nv = v;
        no = 1'b0;
        case (op)
            OP_LOAD:  nv = ld;
            OP_BCAST: nv = bd;
            OP_INC: begin
                n = v + step;
                if (n > MAXV) begin
                    no = 1'b1;
                    nv = sat ? MAXV : n - (MAXV + 1);
                end else nv = n;
            end
            OP_DEC: begin
                n = v - step;
                if (n < 0) begin
                    no = 1'b1;
                    nv = sat ? 0 : n + (MAXV + 1);
                end else nv = n;
            end
            default: nv = v;
        endcase
    endfunction

    always @(posedge clk) begin
        logic [EW-1:0] ew, es;
        if (rst) begin
            for (int c = 0; c < N; c++) begin
                mW[c] = 0; mS[c] = 0; oW[c] = 0; oS[c] = 0;
            end
            modelValid = 1'b1;
        end else if (modelValid) begin
            for (int c = 0; c < N; c++) begin
                inc_op_t op;
                int nv;
                bit no;
                op = decode_op(1'b0, wrEn[c], bcastEn, incEn[c], decEn[c]);
                model_next(op, int'(dataIn[c*W +: W]), int'(bcastData), 1, 1'b0, mW[c], nv, no);
                mW[c] = nv; oW[c] = no;
                model_next(op, int'(dataIn[c*W +: W]), int'(bcastData), 3, 1'b1, mS[c], nv, no);
                mS[c] = nv; oS[c] = no;
            end
        end
        if (modelValid) begin
            for (int c = 0; c < N; c++) begin
                ew[c*W +: W] = W'(mW[c]);
                es[c*W +: W] = W'(mS[c]);
                ew[N*W + c]  = oW[c];
                es[N*W + c]  = oS[c];
            end
            expW_q.push_back(ew);
            expS_q.push_back(es);
        end
    end

    // Scoreboard compare, away from the active edge
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (expW_q.size() > 0) begin
            e = expW_q.pop_front();
            compared++;
            if ({ovfW, outW} !== e) begin
                mismatched++;
                $display("FAIL cycle_wrap t=%0t got=%h exp=%h", $time, {ovfW, outW}, e);
            end
        end
        if (expS_q.size() > 0) begin
            e = expS_q.pop_front();
            compared++;
            if ({ovfS, outS} !== e) begin
                mismatched++;
                $display("FAIL cycle_sat t=%0t got=%h exp=%h", $time, {ovfS, outS}, e);
            end
        end
    end

    // Driver tasks
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [N-1:0] wr, input logic [N-1:0] inc, input logic [N-1:0] dec,
                         input logic bc, input int bd);
        wrEn = wr; incEn = inc; decEn = dec; bcastEn = bc; bcastData = W'(bd);
    endtask

    task automatic set_data(input int c, input int v);
        dataIn[c*W +: W] = W'(v);
    endtask

    function automatic int chW(input int c);
        return int'(outW[c*W +: W]);
    endfunction

    function automatic int chS(input int c);
        return int'(outS[c*W +: W]);
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    function automatic int pick_val();
        case ($urandom_range(0, 7))
            0: return 0;
            1: return 1;
            2: return 2;
            3: return MAXV - 2;
            4: return MAXV - 1;
            5: return MAXV;
            default: return int'($urandom_range(0, MAXV));
        endcase
    endfunction

    initial begin
        // Reset and load
        rst = 1'b1;
        cycle();
        chk("reset_ch0", chW(0), 0);
        chk("reset_ch3", chS(3), 0);
        chk("reset_ovf", int'(ovfW), 0);
        rst = 1'b0;
        set_data(0, 23);
        drive(4'b0001, 4'b0000, 4'b0000, 1'b0, 0);
        cycle();
        chk("load_ch0", chW(0), 23);
        chk("load_ch1", chW(1), 0);
        chk("load_ovf", int'(ovfW), 0);
        drive(4'b0000, 4'b0001, 4'b0000, 1'b0, 0);
        cycle();
        chk("inc_ch0", chW(0), 24);
        chk("inc_step3_ch0", chS(0), 26);

        // Wrap on channel 2
        set_data(2, 4094);
        drive(4'b0100, 4'b0000, 4'b0000, 1'b0, 0);
        cycle();
        drive(4'b0000, 4'b0100, 4'b0000, 1'b0, 0);
        cycle();
        chk("wrap_a", chW(2), 4095);
        chk("wrap_a_ovf", int'(ovfW[2]), 0);
        cycle();
        chk("wrap_b", chW(2), 0);
        chk("wrap_b_ovf", int'(ovfW[2]), 1);
        cycle();
        chk("wrap_c", chW(2), 1);
        chk("wrap_c_ovf", int'(ovfW[2]), 0);

        // Saturate on channel 1 (step 3)
        set_data(1, 2);
        drive(4'b0010, 4'b0000, 4'b0000, 1'b0, 0);
        cycle();
        drive(4'b0000, 4'b0000, 4'b0010, 1'b0, 0);
        cycle();
        chk("sat_dec_a", chS(1), 0);
        chk("sat_dec_a_ovf", int'(ovfS[1]), 1);
        cycle();
        chk("sat_dec_b", chS(1), 0);
        chk("sat_dec_b_ovf", int'(ovfS[1]), 1);
        chk("wrap_dec_b", chW(1), 0);
        set_data(1, 4094);
        drive(4'b0010, 4'b0000, 4'b0000, 1'b0, 0);
        cycle();
        drive(4'b0000, 4'b0010, 4'b0000, 1'b0, 0);
        cycle();
        chk("sat_inc", chS(1), 4095);
        chk("sat_inc_ovf", int'(ovfS[1]), 1);

        // Broadcast vs local load
        set_data(2, 15);
        drive(4'b0100, 4'b0000, 4'b0000, 1'b1, 36);
        cycle();
        chk("bcast_ch0", chW(0), 36);
        chk("bcast_ch1", chW(1), 36);
        chk("bcast_ch2_local", chW(2), 15);
        chk("bcast_ch3", chW(3), 36);
        drive(4'b0000, 4'b0001, 4'b0001, 1'b0, 0);
        cycle();
        chk("incdec_hold", chW(0), 36);
        chk("incdec_ovf", int'(ovfW[0]), 0);

        // Reset mid-count on channel 3
        set_data(3, 100);
        drive(4'b1000, 4'b0000, 4'b0000, 1'b0, 0);
        cycle();
        drive(4'b0000, 4'b1000, 4'b0000, 1'b0, 0);
        repeat (4) cycle();
        chk("count_104", chW(3), 104);
        rst = 1'b1;
        cycle();
        chk("midreset_ch3", chW(3), 0);
        chk("midreset_ch0", chW(0), 0);
        rst = 1'b0;
        cycle();
        chk("resume_1", chW(3), 1);
        cycle();
        chk("resume_2", chW(3), 2);

        // Random traffic checked by the scoreboard each cycle
        for (int i = 0; i < 1000; i++) begin
            for (int c = 0; c < N; c++) set_data(c, pick_val());
            drive(4'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15)),
                  4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15) & $urandom_range(0, 15)),
                  ($urandom_range(0, 15) == 0), pick_val());
            rst = ($urandom_range(0, 99) == 0);
            cycle();
        end
        rst = 1'b0;
        drive('0, '0, '0, 1'b0, 0);

        // Drain the scoreboard with a bounded wait
        begin
            int budget;
            budget = 10;
            while ((expW_q.size() > 0 || expS_q.size() > 0) && budget > 0) begin
                @(negedge clk);
                #1;
                budget--;
            end
            compared++;
            if (expW_q.size() > 0 || expS_q.size() > 0) begin
                mismatched++;
                $display("FAIL drain got=%0d pending exp=0", expW_q.size() + expS_q.size());
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
